// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexed scan controller for common-anode 7-segment digits.
//   Holds a frame buffer of DIGITS {char, dot} entries written by two
//   requesters (A has fixed priority over B). It walks the digits and drives
//   the decoder's number/dot/ena/light inputs, with brightness PWM,
//   per-digit blinking and a two-cycle ghost blank at the start of each slot.
//   digit_sel trails number/ena/light by one cycle so that it lines up with
//   the decoder's registered segment output.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr_req_x            write request (x = a, b)
//   wr_idx_x            target digit
//   wr_char_x           character code (0 blank, 1..38 valid, >38 stored as 0)
//   wr_dot_x            dot bit
//   wr_ack_x            one-cycle acknowledge, high the cycle after the commit
//   brightness          PWM on-steps per period (0 dark, >= PWM_STEPS full)
//   blink_mask          bit i set makes digit i blink
//   number, dot         character and dot for the decoder
//   ena                 decoder enable (low for the first two cycles of a slot)
//   light               decoder light (PWM and blink gated)
//   digit_sel           one-hot anode select
module display_scan_controller #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 5000,
  parameter int PWM_STEPS = 8,
  parameter int BLINK_DIV = 256,
  localparam int IW  = $clog2(DIGITS),
  localparam int BRW = $clog2(PWM_STEPS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_a,
  input  logic [IW-1:0]     wr_idx_a,
  input  logic [5:0]        wr_char_a,
  input  logic              wr_dot_a,
  output logic              wr_ack_a,
  input  logic              wr_req_b,
  input  logic [IW-1:0]     wr_idx_b,
  input  logic [5:0]        wr_char_b,
  input  logic              wr_dot_b,
  output logic              wr_ack_b,
  input  logic [BRW-1:0]    brightness,
  input  logic [DIGITS-1:0] blink_mask,
  output logic [5:0]        number,
  output logic              dot,
  output logic              ena,
  output logic              light,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PW  = BRW - 1;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0]  SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]  BLANK_END  = SW'(2);
  localparam logic [IW-1:0]  CUR_LAST   = IW'(DIGITS - 1);
  localparam logic [PW-1:0]  P_LAST     = PW'(PWM_STEPS - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

  // ---------------- write arbitration ----------------
  logic          ack_a_reg, ack_b_reg;
  logic          elig_a, elig_b, grant_a, grant_b, commit;
  logic [IW-1:0] sel_idx;
  logic [5:0]    sel_char;
  logic          sel_dot;
  logic [6:0]    sel_entry;

  // A requester whose ack is currently high is still holding the request it
  // just got accepted, so it is excluded to avoid a duplicate commit.
  always_comb begin
    elig_a    = wr_req_a & ~ack_a_reg;
    elig_b    = wr_req_b & ~ack_b_reg;
    grant_a   = elig_a;
    grant_b   = elig_b & ~elig_a;
    sel_idx   = grant_a ? wr_idx_a  : wr_idx_b;
    sel_char  = grant_a ? wr_char_a : wr_char_b;
    sel_dot   = grant_a ? wr_dot_a  : wr_dot_b;
    // Out-of-range indices are still acknowledged, just not stored.
    commit    = (grant_a | grant_b) & (int'(sel_idx) < DIGITS);
    sel_entry = {(sel_char > 6'd38) ? 6'd0 : sel_char, sel_dot};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_a_reg <= 1'b0;
      ack_b_reg <= 1'b0;
    end else begin
      ack_a_reg <= grant_a;
      ack_b_reg <= grant_b;
    end
  end

  assign wr_ack_a = ack_a_reg;
  assign wr_ack_b = ack_b_reg;

  // ---------------- frame buffer ----------------
  logic [6:0] buffer [DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_buf
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        buffer[gi] <= '0;
      else if (commit && (sel_idx == IW'(gi)))
        buffer[gi] <= sel_entry;
    end
  end

  // ---------------- scan, PWM and blink counters ----------------
  logic [SW-1:0]  slot_reg, slot_next;
  logic [IW-1:0]  cur_reg, cur_next;
  logic [PW-1:0]  p_reg, p_next;
  logic [BCW-1:0] blink_cnt_reg, blink_cnt_next;
  logic           phase_reg, phase_next;
  logic           slot_wrap;

  always_comb begin
    slot_wrap      = (slot_reg == SLOT_LAST);
    slot_next      = slot_wrap ? '0 : slot_reg + 1'b1;
    cur_next       = cur_reg;
    blink_cnt_next = blink_cnt_reg;
    phase_next     = phase_reg;
    if (slot_wrap) begin
      cur_next = (cur_reg == CUR_LAST) ? '0 : cur_reg + 1'b1;
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_next = '0;
        phase_next     = ~phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
      end
    end
    p_next = (p_reg == P_LAST) ? '0 : p_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg      <= '0;
      cur_reg       <= '0;
      p_reg         <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else begin
      slot_reg      <= slot_next;
      cur_reg       <= cur_next;
      p_reg         <= p_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
    end
  end

  // ---------------- decoder-side outputs ----------------
  // number/dot/ena/light are registered from the current state; cur_out_reg
  // remembers which digit they belong to so digit_sel can follow one cycle
  // later. out_valid_reg keeps digit_sel dark until the first digit has
  // actually been presented to the decoder.
  logic [5:0]        number_reg, number_next;
  logic              dot_reg, dot_next;
  logic              ena_reg, ena_next;
  logic              light_reg, light_next;
  logic [IW-1:0]     cur_out_reg;
  logic              out_valid_reg;
  logic [DIGITS-1:0] digit_sel_reg, digit_sel_next;

  always_comb begin
    number_next = buffer[cur_reg][6:1];
    dot_next    = buffer[cur_reg][0];
    ena_next    = (slot_reg >= BLANK_END);
    light_next  = (BRW'(p_reg) < brightness) & ~(phase_reg & blink_mask[cur_reg]);
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
    assign digit_sel_next[gi] = out_valid_reg & (cur_out_reg == IW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      number_reg    <= '0;
      dot_reg       <= 1'b0;
      ena_reg       <= 1'b0;
      light_reg     <= 1'b0;
      cur_out_reg   <= '0;
      out_valid_reg <= 1'b0;
      digit_sel_reg <= '0;
    end else begin
      number_reg    <= number_next;
      dot_reg       <= dot_next;
      ena_reg       <= ena_next;
      light_reg     <= light_next;
      cur_out_reg   <= cur_reg;
      out_valid_reg <= 1'b1;
      digit_sel_reg <= digit_sel_next;
    end
  end

  assign number    = number_reg;
  assign dot       = dot_reg;
  assign ena       = ena_reg;
  assign light     = light_reg;
  assign digit_sel = digit_sel_reg;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
//   Scoreboarded bench for display_scan_controller (DIGITS=4, SCAN_DIV=8,
//   PWM_STEPS=8, BLINK_DIV=2). Writes push their expected buffer entry into a
//   per-requester queue; the entry is popped into a model frame buffer when
//   the DUT acknowledges. Every cycle the outputs are compared against a
//   closed-form model of the scan position derived from the cycle count.
//   A second instance with DIGITS=3 covers an out-of-range write index.
module tb_display_scan_controller;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int PWM_STEPS = 8;
  localparam int BLINK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_req_a = 1'b0, wr_req_b = 1'b0;
  logic [1:0] wr_idx_a = '0, wr_idx_b = '0;
  logic [5:0] wr_char_a = '0, wr_char_b = '0;
  logic       wr_dot_a = 1'b0, wr_dot_b = 1'b0;
  logic       wr_ack_a, wr_ack_b;
  logic [3:0] brightness = 4'd8;
  logic [3:0] blink_mask = '0;
  logic [5:0] number;
  logic       dot, ena, light;
  logic [3:0] digit_sel;

  // second instance, three digits
  logic       req3 = 1'b0;
  logic [1:0] idx3 = '0;
  logic [5:0] char3 = '0;
  logic       dot3_in = 1'b0;
  logic       ack3_a, ack3_b;
  logic [5:0] num3;
  logic       dot3, ena3, light3;
  logic [2:0] sel3;
  logic       zero_req = 1'b0;
  logic [1:0] zero_idx = '0;
  logic [5:0] zero_char = '0;

  always #5 clk = ~clk;

  display_scan_controller #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .PWM_STEPS(PWM_STEPS), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req_a(wr_req_a), .wr_idx_a(wr_idx_a), .wr_char_a(wr_char_a), .wr_dot_a(wr_dot_a), .wr_ack_a(wr_ack_a),
    .wr_req_b(wr_req_b), .wr_idx_b(wr_idx_b), .wr_char_b(wr_char_b), .wr_dot_b(wr_dot_b), .wr_ack_b(wr_ack_b),
    .brightness(brightness), .blink_mask(blink_mask),
    .number(number), .dot(dot), .ena(ena), .light(light), .digit_sel(digit_sel)
  );

  display_scan_controller #(
    .DIGITS(3), .SCAN_DIV(4), .PWM_STEPS(8), .BLINK_DIV(2)
  ) dut3 (
    .clk(clk), .rst(rst),
    .wr_req_a(req3), .wr_idx_a(idx3), .wr_char_a(char3), .wr_dot_a(dot3_in), .wr_ack_a(ack3_a),
    .wr_req_b(zero_req), .wr_idx_b(zero_idx), .wr_char_b(zero_char), .wr_dot_b(zero_req), .wr_ack_b(ack3_b),
    .brightness(brightness), .blink_mask(blink_mask[2:0]),
    .number(num3), .dot(dot3), .ena(ena3), .light(light3), .digit_sel(sel3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    int         idx;
    logic [6:0] entry;
  } wr_t;

  wr_t        qa[$];
  wr_t        qb[$];
  logic [6:0] mbuf [DIGITS];
  int         n;
  logic [3:0] br_s, mask_s;
  int         ack_a_n = 0, ack_b_n = 0;

  initial for (int i = 0; i < DIGITS; i++) mbuf[i] = '0;

  // cycles since reset release; brightness/mask as seen by the DUT at each edge
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end
  always @(posedge clk) begin
    br_s   <= brightness;
    mask_s <= blink_mask;
  end

  // Output monitor: compare first (outputs after edge n reflect the buffer
  // before edge n), then retire acknowledged writes into the model buffer.
  always @(negedge clk) begin
    int         s, slot, cur, p, phase;
    logic [3:0] sel_e;
    logic [6:0] e;
    wr_t        w;
    if (!rst && n >= 1) begin
      s     = n - 1;
      slot  = s % SCAN_DIV;
      cur   = (s / SCAN_DIV) % DIGITS;
      p     = s % PWM_STEPS;
      phase = (s / SCAN_DIV / BLINK_DIV) % 2;
      e     = mbuf[cur];
      sel_e = (n >= 2) ? 4'(1 << (((n - 2) / SCAN_DIV) % DIGITS)) : 4'd0;
      check("digit_sel", 32'(digit_sel), 32'(sel_e));
      check("ena", 32'(ena), 32'(slot >= 2));
      check("number", 32'(number), 32'(e[6:1]));
      check("dot", 32'(dot), 32'(e[0]));
      check("light", 32'(light), 32'((p < int'(br_s)) && !(phase == 1 && mask_s[cur])));
    end
    if (wr_ack_a) begin
      ack_a_n = n;
      if (qa.size() == 0) check("ack_a_spurious", 1, 0);
      else begin
        w = qa.pop_front();
        if (w.idx < DIGITS) mbuf[w.idx] = w.entry;
      end
    end
    if (wr_ack_b) begin
      ack_b_n = n;
      if (qb.size() == 0) check("ack_b_spurious", 1, 0);
      else begin
        w = qb.pop_front();
        if (w.idx < DIGITS) mbuf[w.idx] = w.entry;
      end
    end
  end

  // Requesters hold the request through the ack cycle and drop it one cycle
  // later, which exercises the "held request is not re-accepted" rule.
  task automatic write_a(input int idx, input int ch, input bit d, input int lat);
    wr_t w;
    bit  got;
    int  waited;
    @(negedge clk);
    wr_idx_a = 2'(idx); wr_char_a = 6'(ch); wr_dot_a = d; wr_req_a = 1'b1;
    w.idx = idx; w.entry = {(ch > 38) ? 6'd0 : 6'(ch), d};
    qa.push_back(w);
    got = 0; waited = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (wr_ack_a) begin got = 1; waited = i; end
    end
    check("ack_a_latency", got ? waited : 99, lat);
    @(negedge clk);
    wr_req_a = 1'b0;
  endtask

  task automatic write_b(input int idx, input int ch, input bit d, input int lat);
    wr_t w;
    bit  got;
    int  waited;
    @(negedge clk);
    wr_idx_b = 2'(idx); wr_char_b = 6'(ch); wr_dot_b = d; wr_req_b = 1'b1;
    w.idx = idx; w.entry = {(ch > 38) ? 6'd0 : 6'(ch), d};
    qb.push_back(w);
    got = 0; waited = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (wr_ack_b) begin got = 1; waited = i; end
    end
    check("ack_b_latency", got ? waited : 99, lat);
    @(negedge clk);
    wr_req_b = 1'b0;
  endtask

  task automatic count_light(input int exp_n, input string tag);
    int c;
    c = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < PWM_STEPS; i++) begin
      @(negedge clk);
      c += int'(light);
    end
    check(tag, c, exp_n);
  endtask

  initial begin
    bit got;
    int waited;

    repeat (3) @(negedge clk);
    check("rst_number", 32'(number), 0);
    check("rst_dot", 32'(dot), 0);
    check("rst_ena", 32'(ena), 0);
    check("rst_light", 32'(light), 0);
    check("rst_digit_sel", 32'(digit_sel), 0);
    check("rst_ack_a", 32'(wr_ack_a), 0);
    check("rst_ack_b", 32'(wr_ack_b), 0);
    rst = 1'b0;

    // idle walk across all digits
    repeat (40) @(negedge clk);

    write_a(2, 4, 1'b1, 0);
    repeat (40) @(negedge clk);

    // simultaneous requests: A first, B on the following cycle
    fork
      write_a(0, 11, 1'b0, 0);
      write_b(1, 12, 1'b0, 1);
    join
    check("ab_ack_spacing", ack_b_n - ack_a_n, 1);
    repeat (36) @(negedge clk);

    // out-of-range character is stored as blank
    write_a(1, 45, 1'b0, 0);
    repeat (36) @(negedge clk);

    brightness = 4'd3;
    count_light(3, "light_count_b3");
    brightness = 4'd8;
    count_light(8, "light_count_b8");
    brightness = 4'd0;
    count_light(0, "light_count_b0");
    brightness = 4'd5;
    repeat (10) @(negedge clk);

    write_a(3, 38, 1'b1, 0);
    blink_mask = 4'b0010;
    repeat (80) @(negedge clk);

    // reset in the middle of blinking with a request in flight
    @(negedge clk);
    #2;
    wr_idx_a = 2'd3; wr_char_a = 6'd9; wr_dot_a = 1'b1; wr_req_a = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_number", 32'(number), 0);
    check("midrst_dot", 32'(dot), 0);
    check("midrst_ena", 32'(ena), 0);
    check("midrst_light", 32'(light), 0);
    check("midrst_digit_sel", 32'(digit_sel), 0);
    check("midrst_ack_a", 32'(wr_ack_a), 0);
    for (int i = 0; i < DIGITS; i++) mbuf[i] = '0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_ack", 32'(wr_ack_a), 0);
    end
    wr_req_a = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // three-digit instance: index 3 is acknowledged but discarded
    @(negedge clk);
    idx3 = 2'd3; char3 = 6'd5; dot3_in = 1'b1; req3 = 1'b1;
    got = 0; waited = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack3_a) begin got = 1; waited = i; end
    end
    check("oob_ack_latency", got ? waited : 99, 0);
    req3 = 1'b0;
    repeat (16) begin
      @(negedge clk);
      check("oob_number", 32'({num3, dot3}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
